// File: rtl/audio_sample_fetch.sv
// audio_sample_fetch: per-channel audio sample sequencer feeding the sigma-delta DAC.
// Fetches 16-bit words (two signed 8-bit samples, high byte first) over a req/ack
// port, steps samples at a programmable period, loops the buffer and drives an
// offset-binary 8-bit sample.
// Optional feature: define AUDIO_VOLUME_EN to enable the volume multiplier
// (adds one pipeline clock between a sample tick and sample_o).
module audio_sample_fetch #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEN_W    = 15,
  parameter int unsigned PERIOD_W = 15
) (
  input  logic                clk,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [7:0]          volume_i,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [15:0]         mem_data_i,
  output logic                restart_o,
  output logic                underrun_o,
  output logic [7:0]          sample_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam logic [7:0] MIDSCALE = 8'h80;

  // Control state
  logic [1:0]          state_q,      state_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [LEN_W-1:0]    len_q,        len_d;
  logic [PERIOD_W-1:0] period_q,     period_d;
  logic [ADDR_W-1:0]   ptr_q,        ptr_d;
  logic [LEN_W-1:0]    count_q,      count_d;
  logic [PERIOD_W-1:0] per_cnt_q,    per_cnt_d;
  logic                req_q,        req_d;
  logic                restart_q,    restart_d;
  logic                underrun_q,   underrun_d;

  // Sample buffers
  logic [15:0]         cur_q,        cur_d;
  logic                sel_lo_q,     sel_lo_d;
  logic [15:0]         next_q,       next_d;
  logic                next_vld_q,   next_vld_d;
  logic                upd_q,        upd_d;

  // Output path
  logic [7:0]          sample_q,     sample_d;
  logic [7:0]          sel_byte;

  logic                ack_ok;
  logic                tick;
  logic                kill;

  // An ack only counts while a request is actually outstanding
  assign ack_ok = mem_ack_i && req_q && (state_q != ST_IDLE);
  assign tick   = (state_q == ST_PLAY) && (per_cnt_q == '0);
  assign kill   = stop_i && !start_i;

  // Register bank for control state and buffers
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      start_addr_q <= '0;
      len_q        <= '0;
      period_q     <= '0;
      ptr_q        <= '0;
      count_q      <= '0;
      per_cnt_q    <= '0;
      req_q        <= 1'b0;
      restart_q    <= 1'b0;
      underrun_q   <= 1'b0;
      cur_q        <= '0;
      sel_lo_q     <= 1'b0;
      next_q       <= '0;
      next_vld_q   <= 1'b0;
      upd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      len_q        <= len_d;
      period_q     <= period_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      per_cnt_q    <= per_cnt_d;
      req_q        <= req_d;
      restart_q    <= restart_d;
      underrun_q   <= underrun_d;
      cur_q        <= cur_d;
      sel_lo_q     <= sel_lo_d;
      next_q       <= next_d;
      next_vld_q   <= next_vld_d;
      upd_q        <= upd_d;
    end
  end

  // Next-state: start/stop, fetch handshake, period counter and sample stepping
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    len_d        = len_q;
    period_d     = period_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    per_cnt_d    = per_cnt_q;
    req_d        = req_q;
    restart_d    = 1'b0;
    underrun_d   = underrun_q;
    cur_d        = cur_q;
    sel_lo_d     = sel_lo_q;
    next_d       = next_q;
    next_vld_d   = next_vld_q;
    upd_d        = 1'b0;

    if (start_i) begin
      // Restart wins over stop; any in-flight request is abandoned
      state_d      = ST_FILL;
      start_addr_d = addr_i;
      len_d        = len_i;
      period_d     = period_i;
      ptr_d        = addr_i;
      count_d      = len_i;
      per_cnt_d    = period_i;
      req_d        = 1'b0;
      underrun_d   = 1'b0;
      sel_lo_d     = 1'b0;
      next_vld_d   = 1'b0;
    end else if (stop_i) begin
      state_d    = ST_IDLE;
      req_d      = 1'b0;
      next_vld_d = 1'b0;
    end else begin
      if (ack_ok) begin
        ptr_d     = (count_q == '0) ? start_addr_q : ptr_q + ADDR_W'(1);
        count_d   = (count_q == '0) ? len_q : count_q - LEN_W'(1);
        restart_d = (count_q == '0);
        if (state_q == ST_FILL) begin
          // First word goes straight to the playing buffer
          cur_d     = mem_data_i;
          sel_lo_d  = 1'b0;
          state_d   = ST_PLAY;
          per_cnt_d = period_q;
          upd_d     = 1'b1;
        end else begin
          next_d     = mem_data_i;
          next_vld_d = 1'b1;
        end
      end

      if (state_q == ST_PLAY) begin
        if (tick) begin
          per_cnt_d = period_q;
          upd_d     = 1'b1;
          if (!sel_lo_q) begin
            sel_lo_d = 1'b1;
          end else if (next_vld_q || ack_ok) begin
            // A word arriving on the tick clock is consumed directly
            cur_d      = next_vld_q ? next_q : mem_data_i;
            next_vld_d = 1'b0;
            sel_lo_d   = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          per_cnt_d = per_cnt_q - PERIOD_W'(1);
        end
      end

      // Request whenever the next buffer is empty; drop for one clock after an ack
      req_d = (state_d != ST_IDLE) && !next_vld_d && !ack_ok;
    end
  end

  assign sel_byte = sel_lo_q ? cur_q[7:0] : cur_q[15:8];

`ifdef AUDIO_VOLUME_EN
  logic signed [7:0]  s_sel;
  logic signed [15:0] prod;
  logic signed [15:0] shr;
  logic [7:0]         scaled;
  logic [7:0]         scaled_q, scaled_d;
  logic               pv_q,     pv_d;

  // Signed sample times unsigned gain (0x80 = unity), saturated to 8 bits
  always_comb begin
    s_sel = $signed(sel_byte);
    prod  = 16'(s_sel) * 16'($signed({1'b0, volume_i}));
    shr   = prod >>> 7;
    if (shr > 16'sd127) begin
      scaled = 8'h7F;
    end else if (shr < -16'sd128) begin
      scaled = 8'h80;
    end else begin
      scaled = shr[7:0];
    end
  end

  // Two-stage output: scale on the update clock, convert to offset binary next
  always_comb begin
    scaled_d = scaled_q;
    pv_d     = 1'b0;
    sample_d = sample_q;
    if (kill) begin
      sample_d = MIDSCALE;
    end else begin
      if (upd_q) begin
        scaled_d = scaled;
        pv_d     = 1'b1;
      end
      if (pv_q) begin
        sample_d = scaled_q ^ MIDSCALE;
      end
    end
  end

  // Output pipeline registers
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      scaled_q <= '0;
      pv_q     <= 1'b0;
      sample_q <= MIDSCALE;
    end else begin
      scaled_q <= scaled_d;
      pv_q     <= pv_d;
      sample_q <= sample_d;
    end
  end
`else
  logic unused_volume;
  assign unused_volume = ^volume_i;

  // Single-stage output: selected byte converted to offset binary
  always_comb begin
    sample_d = sample_q;
    if (kill) begin
      sample_d = MIDSCALE;
    end else if (upd_q) begin
      sample_d = sel_byte ^ MIDSCALE;
    end
  end

  // Output sample register
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      sample_q <= MIDSCALE;
    end else begin
      sample_q <= sample_d;
    end
  end
`endif

  assign mem_req_o  = req_q;
  assign mem_addr_o = ptr_q;
  assign restart_o  = restart_q;
  assign underrun_o = underrun_q;
  assign sample_o   = sample_q;

endmodule

// File: tb/tb_audio_sample_fetch.sv
// Directed bench for audio_sample_fetch with a zero-wait memory responder,
// an acceptance/restart monitor and an expected-sample scoreboard queue.
module tb_audio_sample_fetch;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned LEN_W    = 15;
  localparam int unsigned PERIOD_W = 15;

  logic                clk;
  logic                reset_ni;
  logic                start_i;
  logic                stop_i;
  logic [ADDR_W-1:0]   addr_i;
  logic [LEN_W-1:0]    len_i;
  logic [PERIOD_W-1:0] period_i;
  logic [7:0]          volume_i;
  logic                mem_req_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic                mem_ack_i;
  logic [15:0]         mem_data_i;
  logic                restart_o;
  logic                underrun_o;
  logic [7:0]          sample_o;

  int checks = 0;
  int errors = 0;

  logic        withhold  = 1'b0;
  logic        stray_ack = 1'b0;
  logic [15:0] acc_q[$];
  logic [7:0]  exp_q[$];
  int          pulses = 0;
  int          wide   = 0;
  logic        restart_prev = 1'b0;

  audio_sample_fetch #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .addr_i    (addr_i),
    .len_i     (len_i),
    .period_i  (period_i),
    .volume_i  (volume_i),
    .mem_req_o (mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i (mem_ack_i),
    .mem_data_i(mem_data_i),
    .restart_o (restart_o),
    .underrun_o(underrun_o),
    .sample_o  (sample_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0100: mem_word = 16'h7F80;
      16'h0101: mem_word = 16'h0001;
      default:  mem_word = 16'hA5A5;
    endcase
  endfunction

  // Zero-wait memory: ack the first clock a request is seen
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if ((mem_req_o && !withhold) || stray_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o);
      end else begin
        mem_ack_i  = 1'b0;
      end
    end
  end

  // Mid-cycle monitor: accepted fetch addresses and restart pulse shape
  initial begin
    forever begin
      @(negedge clk);
      if (reset_ni && mem_ack_i && mem_req_o && !start_i && !stop_i)
        acc_q.push_back(mem_addr_o);
      if (restart_o) begin
        pulses++;
        if (restart_prev) wide++;
      end
      restart_prev = restart_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] a, input logic [14:0] l, input logic [14:0] p);
    addr_i   = a;
    len_i    = l;
    period_i = p;
    start_i  = 1'b1;
    step(1);
    start_i  = 1'b0;
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
  endtask

  // Wait (bounded) for sample_o to change, then compare against the scoreboard head
  task automatic next_sample(input string tag, input int bound, output int cyc);
    logic [7:0] prev;
    logic [7:0] exp;
    int n;
    prev = sample_o;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sample_o === prev && n < bound);
    check({tag, "_changed"}, 32'(sample_o !== prev), 32'd1);
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check(tag, 32'(sample_o), 32'(exp));
    cyc = n;
  endtask

  task automatic wait_sample(input string tag, input logic [7:0] val, input int bound);
    int n;
    n = 0;
    while (sample_o !== val && n < bound) begin
      step(1);
      n++;
    end
    check(tag, 32'(sample_o), 32'(val));
  endtask

  int   cyc;
  int   wraps;
  logic [7:0] hold;

  initial begin
    reset_ni = 1'b0;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    addr_i   = '0;
    len_i    = '0;
    period_i = '0;
    volume_i = 8'h80;

    // Reset values
    step(3);
    check("rst_sample",   32'(sample_o),   32'h80);
    check("rst_req",      32'(mem_req_o),  32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    check("rst_restart",  32'(restart_o),  32'd0);
    check("rst_addr",     32'(mem_addr_o), 32'h0);
    @(negedge clk);
    reset_ni = 1'b1;
    step(2);

    // Looping playback, period 3, len 1
    acc_q.delete();
    pulses = 0;
    wide   = 0;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h81);
    end
    do_start(16'h0100, 15'd1, 15'd3);
    for (int i = 0; i < 8; i++) begin
      next_sample($sformatf("p3_sample%0d", i), 20, cyc);
      if (i > 0) check($sformatf("p3_spacing%0d", i), 32'(cyc), 32'd4);
    end
    check("p3_underrun", 32'(underrun_o), 32'd0);
    do_stop();
    check("stop_req",    32'(mem_req_o), 32'd0);
    check("stop_sample", 32'(sample_o),  32'h80);
    step(3);
    check("addr0", 32'(acc_q.size() > 0 ? acc_q[0] : 16'hFFFF), 32'h0100);
    check("addr1", 32'(acc_q.size() > 1 ? acc_q[1] : 16'hFFFF), 32'h0101);
    check("addr2", 32'(acc_q.size() > 2 ? acc_q[2] : 16'hFFFF), 32'h0100);
    check("addr3", 32'(acc_q.size() > 3 ? acc_q[3] : 16'hFFFF), 32'h0101);
    wraps = 0;
    foreach (acc_q[k]) if (acc_q[k] == 16'h0101) wraps++;
    check("restart_count", 32'(pulses), 32'(wraps));
    check("restart_seen",  32'(pulses >= 2), 32'd1);
    check("restart_width", 32'(wide), 32'd0);

    // Period 0: fetch keeps up only because same-clock ack feeds the tick
    do_start(16'h0100, 15'd1, 15'd0);
    wait_sample("p0_first", 8'hFF, 20);
`ifdef AUDIO_VOLUME_EN
    wait_sample("p0_sync", 8'h80, 20);
`else
    wait_sample("p0_sync", 8'h81, 20);
`endif
    check("p0_no_underrun", 32'(underrun_o), 32'd0);
    withhold = 1'b1;
    step(20);
    check("ur_set",      32'(underrun_o), 32'd1);
    check("ur_hold",     32'(sample_o),   32'h00);
    check("ur_req",      32'(mem_req_o),  32'd1);
    check("ur_addr",     32'(mem_addr_o), 32'h0101);
    hold = sample_o;
    step(3);
    check("ur_stable",   32'(sample_o),   32'(hold));
    withhold = 1'b0;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    next_sample("resume0", 10, cyc);
    next_sample("resume1", 10, cyc);
    check("ur_sticky",   32'(underrun_o), 32'd1);

    // Stop with a request outstanding; a stray ack afterwards must be ignored
    withhold = 1'b1;
    step(10);
    check("pre_stop_req", 32'(mem_req_o), 32'd1);
    do_stop();
    check("stop2_req",    32'(mem_req_o), 32'd0);
    check("stop2_sample", 32'(sample_o),  32'h80);
    withhold = 1'b0;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    step(5);
    check("idle_req",      32'(mem_req_o),  32'd0);
    check("idle_sample",   32'(sample_o),   32'h80);
    check("idle_underrun", 32'(underrun_o), 32'd1);

    // Restart clears underrun; async reset mid-play with req high
    do_start(16'h0100, 15'd1, 15'd3);
    check("start_clr_underrun", 32'(underrun_o), 32'd0);
    exp_q.push_back(8'hFF);
    next_sample("rs_first", 20, cyc);
    begin
      int n;
      n = 0;
      while (!(mem_req_o && sample_o != 8'h80) && n < 20) begin
        step(1);
        n++;
      end
    end
    check("rs_req_high", 32'(mem_req_o), 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    check("arst_req",      32'(mem_req_o),  32'd0);
    check("arst_sample",   32'(sample_o),   32'h80);
    check("arst_addr",     32'(mem_addr_o), 32'h0);
    check("arst_restart",  32'(restart_o),  32'd0);
    check("arst_underrun", 32'(underrun_o), 32'd0);
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    step(5);
    check("post_rst_req",    32'(mem_req_o), 32'd0);
    check("post_rst_sample", 32'(sample_o),  32'h80);

`ifdef AUDIO_VOLUME_EN
    // Volume scaling: half gain, then mute
    volume_i = 8'h40;
    exp_q.push_back(8'hBF);
    exp_q.push_back(8'h40);
    do_start(16'h0100, 15'd1, 15'd3);
    next_sample("vol_7f", 20, cyc);
    next_sample("vol_80", 20, cyc);
    volume_i = 8'h00;
    step(12);
    check("vol_mute", 32'(sample_o), 32'h80);
    do_stop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
